// File: rtl/stack_sequencer_if.sv
// stack_sequencer_if: word-addressed memory bus between the stack sequencer (master) and its RAM (slave).
interface stack_sequencer_if;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [15:0] mem_addr;
   logic [15:0] mem_w_data;
   logic        mem_ack;
   logic [15:0] mem_r_data;
   modport master(output mem_r_en, mem_w_en, mem_addr, mem_w_data, input mem_ack, mem_r_data);
   modport slave(input mem_r_en, mem_w_en, mem_addr, mem_w_data, output mem_ack, mem_r_data);
endinterface

// File: rtl/stack_sequencer.sv
// stack_sequencer: downward-growing hardware stack for PUSH/POP/CALL/RET/INT with overflow/underflow faults.
module stack_sequencer #(
   parameter logic [15:0] SP_INIT  = 16'hFF00,
   parameter logic [15:0] SP_LIMIT = 16'hF000,
   parameter logic [15:0] IVT_BASE = 16'h0000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [2:0]                op,
   input  logic [15:0]               push_data,
   input  logic [15:0]               ret_pc,
   input  logic [15:0]               cpsr,
   input  logic [15:0]               target,
   input  logic [3:0]                vector,
   stack_sequencer_if.master         bus,
   output logic                      busy,
   output logic                      done,
   output logic                      fault,
   output logic [15:0]               result,
   output logic                      branch_en,
   output logic [15:0]               branch_target,
   output logic [15:0]               sp
);
   localparam logic [2:0] OP_PUSH = 3'd0;
   localparam logic [2:0] OP_POP  = 3'd1;
   localparam logic [2:0] OP_CALL = 3'd2;
   localparam logic [2:0] OP_RET  = 3'd3;
   localparam logic [2:0] OP_INT  = 3'd4;

   typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD, FIN} state_t;
   state_t state, nxt;

   logic [2:0]  op_q;
   logic [15:0] wa_q, cpsr_q, target_q, rd_q;
   logic [3:0]  vector_q;
   logic        fault_q;
   logic [15:0] sp_m1, sp_m2;
   logic        is_rd, is_wr, bad;

   assign sp_m1 = sp - 16'd1;
   assign sp_m2 = sp - 16'd2;
   assign is_rd = op == OP_POP || op == OP_RET;
   assign is_wr = op == OP_PUSH || op == OP_CALL;
   // INT checks room for both words up front so a fault never leaves half a frame behind
   assign bad = op > OP_INT
             || (is_wr && sp_m1 < SP_LIMIT)
             || (op == OP_INT && sp_m2 < SP_LIMIT)
             || (is_rd && sp == SP_INIT);

   always_comb begin
      nxt = state;
      case (state)
         IDLE:     nxt = !start ? IDLE : bad ? FIN : is_rd ? RD : WR_A;
         WR_A:     nxt = !bus.mem_ack ? WR_A : op_q == OP_INT ? WR_B : FIN;
         WR_B, RD: nxt = bus.mem_ack ? FIN : state;
         default:  nxt = IDLE;
      endcase
   end

   assign bus.mem_w_en   = state == WR_A || state == WR_B;
   assign bus.mem_r_en   = state == RD;
   assign bus.mem_addr   = bus.mem_w_en ? sp_m1 : bus.mem_r_en ? sp : 16'h0000;
   assign bus.mem_w_data = state == WR_A ? wa_q : state == WR_B ? cpsr_q : 16'h0000;
   assign busy           = state != IDLE;
   assign done           = state == FIN;
   assign fault          = done && fault_q;
   assign branch_en      = done && !fault_q && (op_q == OP_CALL || op_q == OP_RET || op_q == OP_INT);
   assign branch_target  = !branch_en ? 16'h0000
                         : op_q == OP_CALL ? target_q
                         : op_q == OP_RET ? rd_q
                         : IVT_BASE + {12'd0, vector_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         sp       <= SP_INIT;
         result   <= 16'h0000;
         rd_q     <= 16'h0000;
         op_q     <= 3'd0;
         wa_q     <= 16'h0000;
         cpsr_q   <= 16'h0000;
         target_q <= 16'h0000;
         vector_q <= 4'd0;
         fault_q  <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && start) begin
            op_q     <= op;
            wa_q     <= op == OP_PUSH ? push_data : ret_pc;
            cpsr_q   <= cpsr;
            target_q <= target;
            vector_q <= vector;
            fault_q  <= bad;
         end
         if (bus.mem_ack && bus.mem_w_en) sp <= sp_m1;
         if (bus.mem_ack && bus.mem_r_en) begin
            sp   <= sp + 16'd1;
            rd_q <= bus.mem_r_data;
            if (op_q == OP_POP) result <= bus.mem_r_data;
         end
      end
   end
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: directed checks of the stack sequencer against a behavioural RAM.
module tb_stack_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [15:0] push_data = 16'h0, ret_pc = 16'h0, cpsr = 16'h0, target = 16'h0;
   logic [3:0]  vector = 4'd0;
   logic        busy, done, fault, branch_en;
   logic [15:0] result, branch_target, sp;
   logic        ack_en = 1'b1;
   logic [15:0] mem [0:65535];
   logic [15:0] wa[$], wd[$], ra[$];
   int          tests = 0, fails = 0;
   int          strobe_cnt = 0, both_cnt = 0, done_cnt = 0;
   int          cyc, sc0, dc0;
   logic        f_s, be_s;
   logic [15:0] bt_s;

   stack_sequencer_if bus();

   stack_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .push_data(push_data),
      .ret_pc(ret_pc), .cpsr(cpsr), .target(target), .vector(vector), .bus(bus),
      .busy(busy), .done(done), .fault(fault), .result(result),
      .branch_en(branch_en), .branch_target(branch_target), .sp(sp)
   );

   always #5 clk = ~clk;

   assign bus.mem_ack    = ack_en;
   assign bus.mem_r_data = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (!reset) begin
         if (bus.mem_r_en || bus.mem_w_en) strobe_cnt++;
         if (bus.mem_r_en && bus.mem_w_en) both_cnt++;
         if (bus.mem_w_en && bus.mem_ack) begin
            mem[bus.mem_addr] = bus.mem_w_data;
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_w_data);
         end
         if (bus.mem_r_en && bus.mem_ack) ra.push_back(bus.mem_addr);
      end
   end

   always @(negedge clk) if (done) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_cmd(input logic [2:0] o, input logic [15:0] pd, rp, cp, tg, input logic [3:0] vc);
      wa.delete(); wd.delete(); ra.delete();
      sc0 = strobe_cnt;
      @(negedge clk);
      start = 1'b1; op = o; push_data = pd; ret_pc = rp; cpsr = cp; target = tg; vector = vc;
      cyc = 1;
      do begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
      end while (!done && cyc < 30);
      if (!done) chk("cmd_timeout", {31'd0, done}, 32'd1);
      f_s = fault; be_s = branch_en; bt_s = branch_target;
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_sp", {16'd0, sp}, 32'hFF00);
      chk("rst_flags", {26'd0, busy, done, fault, branch_en, bus.mem_r_en, bus.mem_w_en}, 32'd0);
      chk("rst_regs", {result, bus.mem_addr}, 32'd0);
      chk("rst_regs2", {bus.mem_w_data, branch_target}, 32'd0);

      run_cmd(3'd0, 16'h1234, 16'h0, 16'h0, 16'h0, 4'd0);
      chk("push_cyc", cyc, 3);
      chk("push_wr", {wa[0], wd[0]}, 32'hFEFF_1234);
      chk("push_sp", {16'd0, sp}, 32'hFEFF);
      chk("push_flags", {30'd0, f_s, be_s}, 32'd0);

      run_cmd(3'd1, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0);
      chk("pop_cyc", cyc, 3);
      chk("pop_rd", {16'd0, ra[0]}, 32'hFEFF);
      chk("pop_res_sp", {result, sp}, 32'h1234_FF00);

      run_cmd(3'd4, 16'h0, 16'h0042, 16'h8000, 16'h0, 4'd3);
      chk("int_cyc", cyc, 4);
      chk("int_nwr", wa.size(), 2);
      chk("int_wr0", {wa[0], wd[0]}, 32'hFEFF_0042);
      chk("int_wr1", {wa[1], wd[1]}, 32'hFEFE_8000);
      chk("int_br", {15'd0, be_s, bt_s}, 32'h1_0003);
      chk("int_sp", {16'd0, sp}, 32'hFEFE);

      run_cmd(3'd1, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0);
      chk("pop_cpsr", {result, sp}, 32'h8000_FEFF);
      run_cmd(3'd1, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0);
      chk("pop_retpc", {result, sp}, 32'h0042_FF00);

      run_cmd(3'd2, 16'h0, 16'h0021, 16'h0, 16'h0100, 4'd0);
      chk("call_cyc", cyc, 3);
      chk("call_wr", {wa[0], wd[0]}, 32'hFEFF_0021);
      chk("call_br", {15'd0, be_s, bt_s}, 32'h1_0100);
      run_cmd(3'd3, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0);
      chk("ret_cyc", cyc, 3);
      chk("ret_br", {15'd0, be_s, bt_s}, 32'h1_0021);
      chk("ret_sp_res", {result, sp}, 32'h0042_FF00);

      run_cmd(3'd1, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0);
      chk("unf_cyc", cyc, 2);
      chk("unf_flags", {30'd0, f_s, be_s}, 32'h2);
      chk("unf_nostrobe", strobe_cnt - sc0, 0);
      chk("unf_sp_res", {result, sp}, 32'h0042_FF00);
      run_cmd(3'd3, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0);
      chk("unf_ret", {29'd0, f_s, be_s, 1'b0}, 32'h4);
      run_cmd(3'd7, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0);
      chk("ill_cyc", cyc, 2);
      chk("ill_flags", {30'd0, f_s, be_s}, 32'h2);
      chk("ill_nostrobe", strobe_cnt - sc0, 0);
      chk("ill_sp", {16'd0, sp}, 32'hFF00);

      for (int i = 0; i < 3839; i++) run_cmd(3'd0, 16'(i), 16'h0, 16'h0, 16'h0, 4'd0);
      chk("fill_sp", {16'd0, sp}, 32'hF001);
      run_cmd(3'd4, 16'h0, 16'h0, 16'h0, 16'h0, 4'd1);
      chk("ovf_int", {30'd0, f_s, be_s}, 32'h2);
      chk("ovf_int_nostrobe", strobe_cnt - sc0, 0);
      chk("ovf_int_sp", {16'd0, sp}, 32'hF001);
      run_cmd(3'd0, 16'hAAAA, 16'h0, 16'h0, 16'h0, 4'd0);
      chk("limit_push", {15'd0, f_s, sp}, 32'h0_F000);
      run_cmd(3'd2, 16'h0, 16'h0, 16'h0, 16'h0200, 4'd0);
      chk("ovf_call", {14'd0, f_s, be_s, sp}, 32'h2_F000);
      chk("ovf_call_nostrobe", strobe_cnt - sc0, 0);

      do_reset();
      chk("rst2_sp", {16'd0, sp}, 32'hFF00);

      // PUSH stalled five cycles, with a stray start mid-wait
      ack_en = 1'b0; wa.delete(); wd.delete();
      @(negedge clk); start = 1'b1; op = 3'd0; push_data = 16'hBEEF;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start = (k == 2); op = (k == 2) ? 3'd1 : 3'd0; push_data = (k == 2) ? 16'h7777 : 16'hBEEF;
         chk("stall_hold", {bus.mem_w_en, bus.mem_r_en, done, 13'd0, bus.mem_addr},
             {3'b100, 13'd0, 16'hFEFF});
         chk("stall_data", {16'd0, bus.mem_w_data}, 32'hBEEF);
      end
      ack_en = 1'b1; start = 1'b0;
      @(negedge clk);
      chk("stall_done", {31'd0, done}, 32'd1);
      chk("stall_wr", {wa[0], wd[0]}, 32'hFEFF_BEEF);
      chk("stall_sp", {16'd0, sp}, 32'hFEFF);
      @(negedge clk);
      chk("stray_start_ignored", {31'd0, busy}, 32'd0);

      // reset while waiting on mem_ack discards the command
      ack_en = 1'b0; dc0 = done_cnt;
      @(negedge clk); start = 1'b1; op = 3'd0; push_data = 16'h5555;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         start = 1'b0;
         chk("wait_hold", {bus.mem_w_en, 15'd0, bus.mem_addr}, {1'b1, 15'd0, 16'hFEFE});
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; ack_en = 1'b1;
      chk("abort_state", {14'd0, busy, bus.mem_w_en, sp}, 32'h0_FF00);
      repeat (3) @(negedge clk);
      chk("abort_nodone", done_cnt - dc0, 0);

      run_cmd(3'd0, 16'hC0DE, 16'h0, 16'h0, 16'h0, 4'd0);
      chk("post_abort_push", {wd[0], sp}, 32'hC0DE_FEFF);
      chk("never_both_strobes", both_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SP_INIT  16'hFF00  SP value after reset (empty stack)
- SP_LIMIT  16'hF000  lowest legal stack word
- IVT_BASE  16'h0000  interrupt vector table base
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- start  in  1  accept a command when busy=0
- op  in  3  0=PUSH, 1=POP, 2=CALL, 3=RET, 4=INT, other=illegal
- push_data  in  16  PUSH operand
- ret_pc  in  16  return address saved by CALL/INT
- cpsr  in  16  flags saved by INT
- target  in  16  CALL destination
- vector  in  4  INT vector index
- mem_r_en, mem_w_en  out  1  memory request strobes
- mem_addr  out  16  word address
- mem_w_data  out  16  write data
- mem_ack  in  1  memory request completes this cycle
- mem_r_data  in  16  read data, valid when mem_ack=1
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- fault  out  1  one-cycle pulse: overflow, underflow or illegal op
- result  out  16  POP data
- branch_en  out  1  one-cycle pulse with done for CALL/RET/INT
- branch_target  out  16  new PC, valid while branch_en=1
- sp  out  16  current stack pointer

Function
REQ-003 The stack SHALL grow downward: push writes mem[sp-1] and then sp<=sp-1; pop reads mem[sp] and then sp<=sp+1. All arithmetic SHALL be 16-bit.
REQ-004 States SHALL be IDLE, WR_A, WR_B, RD, FIN.
REQ-005 In IDLE with start=1 (busy=0), the block SHALL latch op and all operands in that cycle, then set busy=1 from the next cycle until FIN completes.
REQ-006 start SHALL be ignored while busy=1.
REQ-007 Transitions from IDLE SHALL be:
- PUSH or CALL: WR_A
- POP or RET: RD
- INT: WR_A then WR_B
- illegal op: FIN with fault
REQ-008 WR_A SHALL write push_data for PUSH and ret_pc for CALL/INT. WR_B SHALL write cpsr.
REQ-009 A memory request SHALL hold the strobe, mem_addr and mem_w_data stable until the cycle mem_ack=1.
REQ-010 The sequencer SHALL update sp in the mem_ack cycle, capture mem_r_data in the mem_ack cycle, and advance state in the following cycle.
REQ-011 mem_r_en and mem_w_en SHALL never be high together, and both SHALL be low outside RD/WR_A/WR_B.
REQ-012 FIN SHALL last 1 cycle: done=1, busy=0 on the next cycle, return to IDLE. A new start SHALL be accepted the cycle after FIN.
REQ-013 In FIN, branch targets SHALL be:
- CALL: branch_en=1, branch_target=target
- RET: branch_en=1, branch_target=popped word
- INT: branch_en=1, branch_target=IVT_BASE+vector
REQ-014 For POP, result SHALL hold the popped word until the next POP completes.
REQ-015 Overflow: if a push would make sp<SP_LIMIT, no memory access SHALL occur, sp SHALL be unchanged, and FIN SHALL assert done=1, fault=1, branch_en=0. For INT, the check SHALL cover both words before any write.
REQ-016 Underflow: a pop with sp==SP_INIT SHALL behave as in REQ-015, with result unchanged.
REQ-017 Minimum latency with mem_ack tied high SHALL be: PUSH/POP/CALL/RET 3 cycles start-to-done, INT 4 cycles, fault 2 cycles.

Reset
REQ-018 With reset=1 at a clk edge, the block SHALL enter IDLE and set: sp=SP_INIT; busy, done, fault, branch_en, mem_r_en, mem_w_en all 0; result, mem_addr, mem_w_data, branch_target all 0.
REQ-019 Reset SHALL override any in-flight command, including one waiting on mem_ack, and SHALL discard that command with no done pulse.

Verification
REQ-020 The bench SHALL cover these directed scenarios (mem_ack tied high unless stated):
- PUSH 16'h1234 after reset -> write addr 16'hFEFF data 16'h1234; done on cycle 3; sp=16'hFEFF.
- Then POP -> read addr 16'hFEFF; result=16'h1234; sp=16'hFF00.
- INT with ret_pc=16'h0042, cpsr=16'h8000, vector=3 -> writes FEFF=0042 then FEFE=8000; branch_target=16'h0003; sp=16'hFEFE; done on cycle 4.
- RET after CALL(target=16'h0100, ret_pc=16'h0021) -> CALL branch_target=16'h0100; RET branch_target=16'h0021; sp back to 16'hFF00.
- POP at reset sp -> fault=1 and done=1 on cycle 2; no mem strobe; sp=16'hFF00. Illegal op 7 -> same behaviour.
- mem_ack held low 5 cycles during PUSH -> strobe, address and data stable throughout; start pulsed mid-wait is ignored; reset asserted on wait cycle 3 -> IDLE, sp=16'hFF00, no done pulse.
